sound_sequencer: RTL

- Parametrised successor of the game's single-channel sample player. Plays one of N_SOUNDS square-wave sound effects from a shared external note ROM onto a 1-bit speaker pin.
- Adds fixed-priority arbitration with preemption, per-sound looping vs one-shot mode, and per-sound ROM base/length tables.
- Sits between the game FSM (sound request levels) and the board speaker pin.

---
 rtl/sound_sequencer_if.sv | 28 ++
 rtl/sound_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer_if.sv
// Bus between the sound sequencer, the game FSM request lines, the note ROM and the speaker pin.
// The sequencer connects through master; the game/board side connects through slave.
interface sound_sequencer_if #(
   parameter int unsigned N_SOUNDS = 6,
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 12
);
   localparam int unsigned ID_W = (N_SOUNDS > 1) ? $clog2(N_SOUNDS) : 1;

   logic [N_SOUNDS-1:0] req;
   logic [ADDR_W-1:0]   rom_addr;
   logic [DATA_W-1:0]   rom_data;
   logic                speaker;
   logic                busy;
   logic [ID_W-1:0]     active_id;
   logic                sound_start;
   logic                sound_done;

   modport master (
      input  req, rom_data,
      output rom_addr, speaker, busy, active_id, sound_start, sound_done
   );

   modport slave (
      output req, rom_data,
      input  rom_addr, speaker, busy, active_id, sound_start, sound_done
   );
endinterface

// File: rtl/sound_sequencer.sv
// Fixed-priority, preemptive square-wave sound effect sequencer.
// It plays half-period note words from a shared ROM onto a 1-bit speaker.
module sound_sequencer #(
   parameter int unsigned N_SOUNDS    = 6,
   parameter int unsigned ADDR_W      = 13,
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned LEN_W       = 12,
   parameter int unsigned DIV_W       = 13,
   parameter int unsigned SAMPLE_DIV  = 4535,
   parameter logic [N_SOUNDS*ADDR_W-1:0] BASE_TABLE  = '0,
   parameter logic [N_SOUNDS*LEN_W-1:0]  LEN_TABLE   = '0,
   parameter logic [N_SOUNDS-1:0]        LOOP_MASK   = N_SOUNDS'(1),
   parameter logic [N_SOUNDS-1:0]        NARROW_MASK = '0,
   parameter int unsigned WIDE_LO     = 1,
   parameter int unsigned WIDE_HI     = 510,
   parameter int unsigned NARROW_LO   = 11,
   parameter int unsigned NARROW_HI   = 37
) (
   input logic               clk,
   input logic               reset,
   sound_sequencer_if.master bus
);
   localparam int unsigned ID_W = (N_SOUNDS > 1) ? $clog2(N_SOUNDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q;
   logic                tick_c;
   logic [N_SOUNDS-1:0] req_q, rise_c, cand_c;
   logic                trig_c, launch_c, release_c;
   logic [ID_W-1:0]     trig_id_c, id_q, id_d;
   logic [LEN_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   note_q, note_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                spk_q, spk_d;
   logic                start_q, start_d;
   logic                done_q, done_d;
   logic                busy_q;
   logic                in_win_c, last_c;
   logic [ADDR_W-1:0]   base_arr [N_SOUNDS];
   logic [LEN_W-1:0]    len_arr  [N_SOUNDS];

   // Per-sound table fields and launch candidates; zero-length sounds never launch.
   for (genvar g = 0; g < N_SOUNDS; g++) begin : g_tab
      assign base_arr[g] = BASE_TABLE[g*ADDR_W +: ADDR_W];
      assign len_arr[g]  = LEN_TABLE[g*LEN_W +: LEN_W];
      assign cand_c[g]   = (len_arr[g] != '0) &&
                           (rise_c[g] || (LOOP_MASK[g] && bus.req[g] && (state_q == S_IDLE)));
   end

   assign rise_c = bus.req & ~req_q;
   assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));

   // Free-running sample divider, untouched by launches.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
      end else if (tick_c) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // Lowest-index candidate wins.
   always_comb begin
      trig_c    = 1'b0;
      trig_id_c = '0;
      for (int i = int'(N_SOUNDS) - 1; i >= 0; i--) begin
         if (cand_c[i]) begin
            trig_c    = 1'b1;
            trig_id_c = ID_W'(i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      idx_d     = idx_q;
      note_d    = note_q;
      addr_d    = addr_q;
      spk_d     = spk_q;
      start_d   = 1'b0;
      done_d    = 1'b0;
      launch_c  = trig_c && ((state_q == S_IDLE) || (trig_id_c < id_q));
      release_c = LOOP_MASK[id_q] && !bus.req[id_q];
      last_c    = (idx_q == len_arr[id_q] - LEN_W'(1));
      in_win_c  = NARROW_MASK[id_q] ?
                  ((bus.rom_data >= DATA_W'(NARROW_LO)) && (bus.rom_data <= DATA_W'(NARROW_HI))) :
                  ((bus.rom_data >= DATA_W'(WIDE_LO))   && (bus.rom_data <= DATA_W'(WIDE_HI)));

      if (launch_c) begin
         // A launch and a preemption are the same operation; preemption beats completion.
         state_d = S_FETCH;
         id_d    = trig_id_c;
         idx_d   = '0;
         note_d  = '0;
         addr_d  = base_arr[trig_id_c];
         spk_d   = 1'b0;
         start_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
            end
            S_FETCH: begin
               if (release_c) begin
                  state_d = S_IDLE;
                  spk_d   = 1'b0;
               end else begin
                  state_d = S_PLAY;
               end
            end
            S_PLAY: begin
               if (release_c) begin
                  state_d = S_IDLE;
                  spk_d   = 1'b0;
               end else if (tick_c) begin
                  if (note_q < bus.rom_data) begin
                     note_d = note_q + DATA_W'(1);
                  end else begin
                     note_d = '0;
                     if (in_win_c) begin
                        spk_d = ~spk_q;
                     end
                     if (!last_c) begin
                        idx_d  = idx_q + LEN_W'(1);
                        addr_d = base_arr[id_q] + ADDR_W'(idx_d);
                     end else if (LOOP_MASK[id_q]) begin
                        idx_d  = '0;
                        addr_d = base_arr[id_q];
                     end else begin
                        done_d  = 1'b1;
                        spk_d   = 1'b0;
                        state_d = S_IDLE;
                     end
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               spk_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         idx_q   <= '0;
         note_q  <= '0;
         addr_q  <= '0;
         spk_q   <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         idx_q   <= idx_d;
         note_q  <= note_d;
         addr_q  <= addr_d;
         spk_q   <= spk_d;
         start_q <= start_d;
         done_q  <= done_d;
         busy_q  <= (state_d != S_IDLE);
         req_q   <= bus.req;
      end
   end

   assign bus.rom_addr    = addr_q;
   assign bus.speaker     = spk_q;
   assign bus.busy        = busy_q;
   assign bus.active_id   = id_q;
   assign bus.sound_start = start_q;
   assign bus.sound_done  = done_q;
endmodule
